// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, constants, op codes and the
// state encoding of the integer-to-float converter.
package fpu_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

    // Operation codes understood by the main fpu block.
    typedef enum logic [2:0] {
        MUL          = 3'b000,
        FLOOR        = 3'b001,
        FLOOR_TO_INT = 3'b010,
        CMP          = 3'b011
    } fpu_op_t;

    // Integer-to-float converter states.
    typedef enum logic [1:0] {
        I2F_IDLE  = 2'd0,
        I2F_NORM  = 2'd1,
        I2F_ROUND = 2'd2,
        I2F_DONE  = 2'd3
    } i2f_state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a normalised magnitude whose hidden bit has already
// been dropped. Input bits [30:8] become the mantissa, bit 7 is the guard bit
// and bits [6:0] fold into sticky. A mantissa carry-out bumps the exponent.
import fpu_pkg::*;

module fpu_round_rne (
    input  logic [30:0]                   mag,
    input  logic [FP_EXP_W-1:0]           exp_in,
    output logic [FP_EXP_W+FP_MANT_W-1:0] result
);

    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [FP_MANT_W:0]   mant_sum;
    logic [FP_EXP_W-1:0]  exp_adj;

    // Decide the rounding increment and fold a mantissa overflow into the exponent.
    always_comb begin
        guard    = mag[7];
        sticky   = |mag[6:0];
        round_up = guard & (sticky | mag[8]);
        mant_sum = {1'b0, mag[30:8]} + {{FP_MANT_W{1'b0}}, round_up};
        exp_adj  = exp_in;
        if (mant_sum[FP_MANT_W]) begin
            // All-ones mantissa rolled over: 1.111..1 + ulp = 10.000..0
            exp_adj = exp_in + {{(FP_EXP_W-1){1'b0}}, 1'b1};
        end
        result = {exp_adj, mant_sum[FP_MANT_W-1:0]};
    end

endmodule

// File: rtl/fpu_int_to_float.sv
// Multi-cycle 32-bit integer to IEEE-754 binary32 converter. The magnitude is
// normalised one bit per cycle, then rounded to nearest-even.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low; valid may not depend on ready. in_ready is high only in IDLE, and
// out_valid/out_data are held stable in DONE until out_ready is seen.
import fpu_pkg::*;

module fpu_int_to_float (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    // Exponent of a value whose leading one sits in bit 31.
    localparam logic [FP_EXP_W-1:0] EXP_START = FP_EXP_W'(FP_BIAS + 31);

    i2f_state_t                       state;
    logic                             sign_r;
    logic [31:0]                      mag_r;
    logic [FP_EXP_W-1:0]              exp_r;
    logic [FP_EXP_W+FP_MANT_W-1:0]    rounded;
    logic                             in_neg;

    assign in_neg   = in_signed & in_data[31];
    assign in_ready = (state == I2F_IDLE);
    assign busy     = (state != I2F_IDLE);

    fpu_round_rne u_round (
        .mag    (mag_r[30:0]),
        .exp_in (exp_r),
        .result (rounded)
    );

    // Converter FSM: capture, normalise, round, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= I2F_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= 32'd0;
            exp_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            case (state)
                I2F_IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_neg;
                        // Negating 0x80000000 yields 0x80000000, which is the right magnitude.
                        mag_r  <= in_neg ? (32'd0 - in_data) : in_data;
                        exp_r  <= EXP_START;
                        if (in_data == 32'd0) begin
                            out_data  <= FP_POS_ZERO;
                            out_valid <= 1'b1;
                            state     <= I2F_DONE;
                        end else begin
                            state     <= I2F_NORM;
                        end
                    end
                end
                I2F_NORM: begin
                    if (mag_r[31]) begin
                        state <= I2F_ROUND;
                    end else begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
                end
                I2F_ROUND: begin
                    out_data  <= {sign_r, rounded};
                    out_valid <= 1'b1;
                    state     <= I2F_DONE;
                end
                I2F_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= I2F_IDLE;
                    end
                end
                default: begin
                    state     <= I2F_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_int_to_float.sv
// Testbench for fpu_int_to_float: directed and random conversions checked by a
// scoreboard against an arithmetic reference model, plus handshake, latency,
// backpressure and asynchronous reset scenarios.
module tb_fpu_int_to_float;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    fpu_int_to_float dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position of the most significant set bit of a nonzero magnitude.
    function automatic int msb_pos(input longint v);
        int p;
        p = 0;
        for (int i = 0; i < 33; i++) begin
            if (((v >> i) & 64'd1) != 0) p = i;
        end
        return p;
    endfunction

    function automatic longint magnitude(input logic [31:0] d, input logic s);
        longint v;
        v = longint'(d);
        if (s && d[31]) v = 64'h1_0000_0000 - v;
        return v;
    endfunction

    function automatic logic [31:0] ref_conv(input logic [31:0] d, input logic s);
        longint v, q, rem, half;
        int     pos, shift, e;
        logic   neg;
        logic [7:0]  e8;
        logic [22:0] m23;
        neg = s && d[31];
        v   = magnitude(d, s);
        if (v == 0) return 32'h00000000;
        pos = msb_pos(v);
        e   = 127 + pos;
        if (pos <= 23) begin
            q = v << (23 - pos);
        end else begin
            shift = pos - 23;
            q     = v >> shift;
            rem   = v - (q << shift);
            half  = longint'(1) << (shift - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        e8  = e[7:0];
        m23 = q[22:0];
        return {neg, e8, m23};
    endfunction

    // Edges from the accept edge (counted as 1) to the first edge with out_valid high.
    function automatic int ref_lat(input logic [31:0] d, input logic s);
        longint v;
        v = magnitude(d, s);
        if (v == 0) return 1;
        return (31 - msb_pos(v)) + 3;
    endfunction

    // ---------------- driver ----------------
    // Call away from a rising edge; returns after the accepting edge (+1).
    task automatic send(input logic [31:0] d, input logic s, output int acc_cyc);
        logic rdy_before;
        int   budget;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        budget    = 0;
        acc_cyc   = -1;
        forever begin
            rdy_before = in_ready;
            @(posedge clk);
            #1;
            if (rdy_before) begin
                acc_cyc = cyc;
                break;
            end
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept expected accept for %h", d);
                break;
            end
        end
        in_valid = 1'b0;
        if (acc_cyc >= 0) begin
            exp_q.push_back(ref_conv(d, s));
            exp_cyc_q.push_back(acc_cyc + ref_lat(d, s) - 1);
        end
    endtask

    task automatic send_nb(input logic [31:0] d, input logic s);
        int acc;
        send(d, s, acc);
    endtask

    // Random consumer backpressure.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_ov    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] held       = 32'd0;

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (exp_cyc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got out_valid=1 expected 0 (data %h)", out_data);
                end else begin
                    check("latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
            if (out_valid && prev_stall) check("stall_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
            prev_ov    = out_valid;
        end else begin
            prev_ov    = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // ---------------- directed vectors ----------------
    logic [31:0] dir_data[12] = '{32'h00000001, 32'hFFFFFFEC, 32'h00000003, 32'h00000000,
                                  32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h80000000, 32'h00FFFFFF, 32'h7FFFFFC0};
    logic        dir_sgn[12]  = '{1'b0, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int          acc;
        int          hs;
        int          n;
        logic [31:0] d;
        logic [31:0] req;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;

        // Reset values while reset is held.
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  out_data,       32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Spot checks of the model itself against hand-derived constants.
        check("model_1",        ref_conv(32'h00000001, 1'b0), 32'h3F800000);
        check("model_tie_up",   ref_conv(32'h01000003, 1'b1), 32'h4B800002);
        check("model_carry",    ref_conv(32'hFFFFFFFF, 1'b0), 32'h4F800000);

        // Directed conversions with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_nb(dir_data[i], dir_sgn[i]);
        wait_drain();

        // Backpressure: hold DONE for 10 cycles, then simultaneous out_ready + in_valid.
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        send_nb(32'hFFFFFFEC, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data_hold", out_data, 32'hC1A00000);
            check("bp_in_ready",  32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        hs = cyc + 1;
        send(32'h00000003, 1'b0, acc);
        check("accept_after_bubble", 32'(acc), 32'(hs + 1));
        rand_ready = 1'b1;
        wait_drain();

        // Asynchronous reset in the middle of normalisation.
        send_nb(32'h00000001, 1'b0);
        repeat (5) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_out_data",  out_data,       32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_nb(32'h00000003, 1'b0);
        wait_drain();

        // Random conversions across all magnitudes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       d = $urandom();
                1:       d = $urandom() >> $urandom_range(0, 31);
                2:       d = 32'd1 << $urandom_range(0, 31);
                3:       d = 32'hFFFFFFFF << $urandom_range(0, 31);
                default: d = $urandom_range(0, 3);
            endcase
            req = 32'($urandom_range(0, 1));
            send_nb(d, req[0]);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpu_int_to_float.md
# fpu_int_to_float

Multi-cycle integer-to-single-precision converter. It is the inverse path of the FPU's floor-to-int operation. It accepts a 32-bit signed or unsigned integer over a valid/ready handshake and normalises it iteratively, one bit per cycle. It then rounds to nearest-even and returns an IEEE-754 binary32 result over a second valid/ready handshake. It sits beside `fpu` in the execute stage and feeds `fpu` operands that originate as integers.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — the single clock; all state changes on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — the input integer is present.
- `in_ready` out 1 — high iff state is IDLE; equal to (state==IDLE).
- `in_data` in 32 — integer operand.
- `in_signed` in 1 — 1: treat `in_data` as two's complement; 0: treat it as unsigned.
- `out_valid` out 1 — result present.
- `out_ready` in 1 — consumer accepts the result.
- `out_data` out 32 — binary32 result.
- `busy` out 1 — high in NORM, ROUND and DONE.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: an accept happens on `in_valid && in_ready`. On accept the block captures the following:
  - sign = `in_signed & in_data[31]`.
  - mag (32b) = sign ? -in_data : in_data. For 0x80000000 signed, mag = 0x80000000.
  - exp (8b) = 158 (bias 127 + 31).
  - If in_data==0: result = 0x00000000 (+0.0) and the next state is DONE. Otherwise the next state is NORM.
- NORM, each cycle:
  - If mag[31]==1, go to ROUND.
  - Otherwise mag <<= 1 and exp -= 1.
  - NORM lasts lz+1 cycles, where lz = leading zeros of mag (0..31).
- ROUND: RNE on the bits of mag.
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up iff guard && (sticky || mant[0]).
  - On mant carry-out (all ones +1): mant = 0 and exp += 1.
  - result = {sign, exp, mant}, then go to DONE.
- DONE: `out_valid`=1 and `out_data`=result, both held stable until `out_ready`. On `out_valid && out_ready` go to IDLE.
- Outputs cannot overflow or produce NaN or Inf; the maximum exponent is 159. -0.0 is never produced.
- `out_data` holds its last value outside DONE; it is not cleared.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, `out_valid`=0, `out_data`=0, `busy`=0. `in_ready`=1 during and after reset.
- Latency, with accept at edge k:
  - Zero input: `out_valid` is high from k+1.
  - Nonzero input: `out_valid` is high from k+lz+3. Examples: 1 gives 34 cycles; 0x80000000 gives 3 cycles.
- Throughput: one conversion in flight. `in_ready`=0 from k+1 until the cycle after the output handshake, so there is a mandatory 1-cycle bubble.
- Simultaneous `out_ready` in DONE and `in_valid` on the same edge: the output completes and the input is NOT accepted; it is accepted in the following IDLE cycle.
- `out_ready` high before DONE has no effect. `in_valid` outside IDLE is ignored, and the input stays pending at the source.
- Reset mid-operation discards the conversion: no `out_valid` pulse, state=IDLE.
- Backpressure: DONE may persist indefinitely; `out_data` must not change while `out_valid && !out_ready`.

## Structure
- Shared package `fpu_pkg` holds:
  - FP_BIAS=127, FP_EXP_W=8, FP_MANT_W=23.
  - FP_POS_ZERO=32'h00000000.
  - the FSM state enum `i2f_state_t`.
  - the existing FPU op codes (MUL=3'b000, FLOOR=3'b001, FLOOR_TO_INT=3'b010, CMP=3'b011), so `fpu` and this block share one definition.
- Sub-module: `fpu_round_rne`, combinational. It takes mag[30:0] and exp, and returns {exp', mant}. It is natural to reuse later in `fpu` multiply rounding. Everything else is inline.

## Test plan
- in_data=0x00000001, in_signed=0 -> `out_data`=0x3F800000, `out_valid` rises exactly 34 cycles after accept.
- in_data=0xFFFFFFEC (−20), in_signed=1 -> 0xC1A00000. Also 3 -> 0x40400000, and 0 -> 0x00000000 one cycle after accept.
- Rounding, with in_signed=1 unless stated:
  - 0x01000001 -> 0x4B800000 (tie to even, down).
  - 0x01000003 -> 0x4B800002 (tie to even, up).
  - 0x7FFFFFFF -> 0x4F000000.
  - 0xFFFFFFFF with in_signed=0 -> 0x4F800000 (mantissa carry).
- 0x80000000: with in_signed=1 -> 0xCF000000; with in_signed=0 -> 0x4F000000, with 3-cycle latency.
- Handshake: hold `out_ready`=0 for 10 cycles in DONE -> `out_data` stable and `in_ready`=0. Then assert `out_ready` and `in_valid` together -> no accept that edge, accept on the next edge.
- Deassert `rst_n` mid-NORM -> all outputs return to reset values immediately (async). After release, a new conversion of 3 yields 0x40400000, with no stale `out_valid`.
